// File: rtl/fpga_exit_reporter_if.sv
// SoC-facing signal bundle for fpga_exit_reporter: UART passthrough, exit handshake and status.
// master = SoC/board side, slave = the reporter itself.
interface fpga_exit_reporter_if;
  logic        soc_uart_tx_i;
  logic        exit_valid_i;
  logic [31:0] exit_value_i;
  logic        uart_tx_o;
  logic        exit_led_o;
  logic        done_o;

  modport master (
    output soc_uart_tx_i,
    output exit_valid_i,
    output exit_value_i,
    input  uart_tx_o,
    input  exit_led_o,
    input  done_o
  );

  modport slave (
    input  soc_uart_tx_i,
    input  exit_valid_i,
    input  exit_value_i,
    output uart_tx_o,
    output exit_led_o,
    output done_o
  );
endinterface

// File: rtl/fpga_exit_reporter.sv
// Passes SoC UART TX through; on exit, waits for line quiet then sends "EXIT XXXXXXXX\r\n".
// Define EXIT_REPORT_VERDICT_EN to append " PASS"/" FAIL" before CR LF (20-byte message).
module fpga_exit_reporter #(
  parameter int unsigned CLK_FREQ_HZ = 50000000,
  parameter int unsigned BAUD_RATE   = 115200,
  parameter int unsigned QUIET_BITS  = 20
) (
  input logic                 clk_i,
  input logic                 rst_ni,
  fpga_exit_reporter_if.slave bus
);

  localparam int unsigned CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE;
  localparam int unsigned QUIET_CLKS   = QUIET_BITS * CLKS_PER_BIT;
  localparam int unsigned BIT_CNT_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned QUIET_CNT_W  = (QUIET_CLKS > 1) ? $clog2(QUIET_CLKS) : 1;
`ifdef EXIT_REPORT_VERDICT_EN
  localparam int unsigned MSG_LEN      = 20;
`else
  localparam int unsigned MSG_LEN      = 15;
`endif

  if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
    $error("fpga_exit_reporter: CLK_FREQ_HZ / BAUD_RATE must be >= 2");
  end
  if (QUIET_BITS < 1) begin : g_bad_quiet_bits
    $error("fpga_exit_reporter: QUIET_BITS must be >= 1");
  end

  typedef enum logic [1:0] {
    IDLE,
    WAIT_QUIET,
    SEND,
    DONE
  } state_t;

  state_t                 state;
  logic [31:0]            exit_value_q;
  logic [QUIET_CNT_W-1:0] quiet_cnt;
  logic [BIT_CNT_W-1:0]   bit_clk_cnt;
  logic [3:0]             bit_idx;
  logic [4:0]             byte_idx;
  logic                   tx_q;
  logic                   exit_led_q;
  logic                   done_q;
  logic [7:0]             cur_byte;

  function automatic logic [7:0] hex_char(input logic [3:0] nib);
    return (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
  endfunction

  // Message ROM, indexed by the byte currently being serialized.
  always_comb begin
    cur_byte = 8'h20;
    case (byte_idx)
      5'd0:  cur_byte = 8'h45;
      5'd1:  cur_byte = 8'h58;
      5'd2:  cur_byte = 8'h49;
      5'd3:  cur_byte = 8'h54;
      5'd4:  cur_byte = 8'h20;
      5'd5:  cur_byte = hex_char(exit_value_q[31:28]);
      5'd6:  cur_byte = hex_char(exit_value_q[27:24]);
      5'd7:  cur_byte = hex_char(exit_value_q[23:20]);
      5'd8:  cur_byte = hex_char(exit_value_q[19:16]);
      5'd9:  cur_byte = hex_char(exit_value_q[15:12]);
      5'd10: cur_byte = hex_char(exit_value_q[11:8]);
      5'd11: cur_byte = hex_char(exit_value_q[7:4]);
      5'd12: cur_byte = hex_char(exit_value_q[3:0]);
`ifdef EXIT_REPORT_VERDICT_EN
      5'd13: cur_byte = 8'h20;
      5'd14: cur_byte = (exit_value_q == '0) ? 8'h50 : 8'h46;
      5'd15: cur_byte = 8'h41;
      5'd16: cur_byte = (exit_value_q == '0) ? 8'h53 : 8'h49;
      5'd17: cur_byte = (exit_value_q == '0) ? 8'h53 : 8'h4C;
      5'd18: cur_byte = 8'h0D;
      5'd19: cur_byte = 8'h0A;
`else
      5'd13: cur_byte = 8'h0D;
      5'd14: cur_byte = 8'h0A;
`endif
      default: cur_byte = 8'h20;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state        <= IDLE;
      exit_value_q <= '0;
      quiet_cnt    <= '0;
      bit_clk_cnt  <= '0;
      bit_idx      <= '0;
      byte_idx     <= '0;
      tx_q         <= 1'b1;
      exit_led_q   <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.exit_valid_i) begin
            exit_value_q <= bus.exit_value_i;
            exit_led_q   <= |bus.exit_value_i;
            quiet_cnt    <= '0;
            state        <= WAIT_QUIET;
          end
        end
        WAIT_QUIET: begin
          if (!bus.soc_uart_tx_i) begin
            quiet_cnt <= '0;
          end else if (quiet_cnt == QUIET_CNT_W'(QUIET_CLKS - 1)) begin
            // Start bit is loaded on the transition edge so it appears on the first SEND cycle.
            state       <= SEND;
            tx_q        <= 1'b0;
            bit_clk_cnt <= '0;
            bit_idx     <= '0;
            byte_idx    <= '0;
          end else begin
            quiet_cnt <= quiet_cnt + QUIET_CNT_W'(1);
          end
        end
        SEND: begin
          if (bit_clk_cnt != BIT_CNT_W'(CLKS_PER_BIT - 1)) begin
            bit_clk_cnt <= bit_clk_cnt + BIT_CNT_W'(1);
          end else begin
            bit_clk_cnt <= '0;
            if (bit_idx == 4'd9) begin
              if (byte_idx == 5'(MSG_LEN - 1)) begin
                state  <= DONE;
                tx_q   <= 1'b1;
                done_q <= 1'b1;
              end else begin
                byte_idx <= byte_idx + 5'd1;
                bit_idx  <= '0;
                tx_q     <= 1'b0;
              end
            end else begin
              // bit_idx is the bit just finished; load the next one (data LSB first, then stop).
              bit_idx <= bit_idx + 4'd1;
              tx_q    <= (bit_idx == 4'd8) ? 1'b1 : cur_byte[bit_idx[2:0]];
            end
          end
        end
        DONE: begin
          done_q <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    case (state)
      SEND:    bus.uart_tx_o = tx_q;
      DONE:    bus.uart_tx_o = 1'b1;
      default: bus.uart_tx_o = bus.soc_uart_tx_i;
    endcase
  end

  assign bus.exit_led_o = exit_led_q;
  assign bus.done_o     = done_q;

endmodule

// File: tb/tb_fpga_exit_reporter.sv
// Self-checking bench for fpga_exit_reporter: vector table, directed corner sequences and
// randomized traffic against a waveform-level reference model.
module tb_fpga_exit_reporter;

  localparam int unsigned CLK_FREQ_HZ = 460800;
  localparam int unsigned BAUD        = 115200;
  localparam int unsigned QUIET_BITS  = 2;
  localparam int unsigned CPB         = CLK_FREQ_HZ / BAUD;
  localparam int unsigned QUIET_CLKS  = QUIET_BITS * CPB;
`ifdef EXIT_REPORT_VERDICT_EN
  localparam int          MSG_LEN     = 20;
`else
  localparam int          MSG_LEN     = 15;
`endif
  localparam int          REPORT_CLKS = MSG_LEN * 10 * int'(CPB);
  localparam int          LATENCY     = 1 + int'(QUIET_CLKS);

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  fpga_exit_reporter_if bus ();

  fpga_exit_reporter #(
    .CLK_FREQ_HZ(CLK_FREQ_HZ),
    .BAUD_RATE  (BAUD),
    .QUIET_BITS (QUIET_BITS)
  ) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  int s_cyc       = 0;
  logic s_uart, s_led, s_done;

  // Reference model: exit capture, run length of high line, and the expected pin waveform.
  bit          m_captured, m_started, m_done;
  logic [31:0] m_val;
  int          m_run;
  bit          m_wave[$];

  function automatic void build_wave(input logic [31:0] v);
    byte unsigned msg[$];
    string        verdict;
    msg = '{8'h45, 8'h58, 8'h49, 8'h54, 8'h20};
    for (int i = 7; i >= 0; i--) begin
      int unsigned n = (v >> (4 * i)) & 32'hF;
      msg.push_back((n < 10) ? 8'(48 + n) : 8'(55 + n));
    end
    verdict = (v == 0) ? " PASS" : " FAIL";
`ifdef EXIT_REPORT_VERDICT_EN
    for (int i = 0; i < verdict.len(); i++) msg.push_back(verdict[i]);
`endif
    msg.push_back(8'h0D);
    msg.push_back(8'h0A);
    m_wave.delete();
    foreach (msg[i]) begin
      repeat (CPB) m_wave.push_back(1'b0);
      for (int b = 0; b < 8; b++) repeat (CPB) m_wave.push_back(msg[i][b]);
      repeat (CPB) m_wave.push_back(1'b1);
    end
  endfunction

  function automatic void model_reset();
    m_captured = 0; m_started = 0; m_done = 0; m_val = '0; m_run = 0;
    m_wave.delete();
  endfunction

  function automatic void model_edge(input bit tx, input bit v, input logic [31:0] val);
    if (!m_captured) begin
      if (v) begin m_captured = 1; m_val = val; m_run = 0; end
    end else if (!m_started) begin
      m_run = tx ? m_run + 1 : 0;
      if (m_run == int'(QUIET_CLKS)) begin m_started = 1; build_wave(m_val); end
    end else if (!m_done) begin
      void'(m_wave.pop_front());
      if (m_wave.size() == 0) m_done = 1;
    end
  endfunction

  function automatic bit m_uart(input bit tx);
    if (m_done) return 1'b1;
    if (m_started) return m_wave[0];
    return tx;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s @cycle %0d: got %0h, expected %0h", name, s_cyc, act, exp);
    end
  endtask

  // One clock: drive inputs mid-cycle, check against the model, then advance the model at the edge.
  task automatic step(input bit r, input bit tx, input bit v, input logic [31:0] val);
    bit eu;
    @(negedge clk);
    rst_n = r;
    bus.soc_uart_tx_i = tx;
    bus.exit_valid_i  = v;
    bus.exit_value_i  = val;
    if (!r) model_reset();
    eu = m_uart(tx);
    #1;
    s_cyc  = cyc;
    s_uart = bus.uart_tx_o;
    s_led  = bus.exit_led_o;
    s_done = bus.done_o;
    chk("uart_tx_o", s_uart, eu);
    chk("exit_led_o", s_led, (m_captured && m_val != 0));
    chk("done_o", s_done, m_done);
    @(posedge clk);
    cyc++;
    if (r) model_edge(tx, v, val);
  endtask

  task automatic wait_done(input int budget, output int first_start, output int done_at);
    int n;
    first_start = -1;
    done_at     = -1;
    n = 0;
    while (done_at < 0 && n < budget) begin
      step(1, 1, 0, 0);
      if (s_uart == 1'b0 && first_start < 0) first_start = s_cyc;
      if (s_done && done_at < 0) done_at = s_cyc;
      n++;
    end
  endtask

  typedef struct {
    bit          rst;
    bit          tx;
    bit          v;
    logic [31:0] val;
    bit          e_uart;
    bit          e_led;
    bit          e_done;
  } vec_t;

  vec_t tbl[9];

  task automatic report_case(input logic [31:0] val, input string tag);
    int c0, fs, da;
    step(0, 1, 0, 0);
    step(1, 1, 1, val);
    c0 = s_cyc;
    wait_done(REPORT_CLKS + 100, fs, da);
    chk({tag, "_start_latency"}, fs - c0, LATENCY);
    chk({tag, "_done_cycle"}, da - c0, LATENCY + REPORT_CLKS);
    chk({tag, "_led"}, s_led, (val != 0));
  endtask

  initial begin
    int c0, fs, da, last_low, takeover_early, extra_low, abort_at, n;
    logic [31:0] val;
    bit tx;

    bus.soc_uart_tx_i = 1'b1;
    bus.exit_valid_i  = 1'b0;
    bus.exit_value_i  = '0;
    model_reset();

    tbl[0] = '{0, 1, 0, 32'h0, 1, 0, 0};
    tbl[1] = '{0, 0, 0, 32'h0, 0, 0, 0};
    tbl[2] = '{1, 0, 0, 32'h0, 0, 0, 0};
    tbl[3] = '{1, 1, 0, 32'h0, 1, 0, 0};
    tbl[4] = '{1, 0, 1, 32'h5, 0, 0, 0};
    tbl[5] = '{1, 1, 0, 32'h0, 1, 1, 0};
    tbl[6] = '{1, 0, 1, 32'h0, 0, 1, 0};
    tbl[7] = '{0, 1, 0, 32'h0, 1, 0, 0};
    tbl[8] = '{1, 0, 0, 32'h0, 0, 0, 0};
    foreach (tbl[i]) begin
      step(tbl[i].rst, tbl[i].tx, tbl[i].v, tbl[i].val);
      chk("tbl_uart", s_uart, tbl[i].e_uart);
      chk("tbl_led", s_led, tbl[i].e_led);
      chk("tbl_done", s_done, tbl[i].e_done);
    end

    // Passthrough under random line activity.
    step(0, 1, 0, 0);
    for (int i = 0; i < 1000; i++) step(1, 1'($urandom_range(0, 1)), 0, $urandom);

    report_case(32'h0000002A, "basic");

    // Quiet gating: takeover only after QUIET_CLKS consecutive high cycles following the last low.
    step(0, 1, 0, 0);
    step(1, 1, 1, 32'hDEADBEEF);
    takeover_early = 0;
    last_low = -1;
    for (int i = 0; i < 100; i++) begin
      tx = (i % 6 == 5) ? 1'b0 : 1'b1;
      step(1, tx, 0, 0);
      if (!tx) last_low = s_cyc;
      if (s_uart !== tx) takeover_early++;
    end
    chk("gate_no_takeover", takeover_early, 0);
    wait_done(REPORT_CLKS + 100, fs, da);
    chk("gate_quiet_gap", fs - last_low - 1, QUIET_CLKS);
    chk("gate_done_cycle", da - fs, REPORT_CLKS);

    // Second exit during SEND must be ignored.
    step(0, 1, 0, 0);
    step(1, 1, 1, 32'h1);
    c0 = s_cyc;
    repeat (100) step(1, 1, 0, 0);
    step(1, 1, 1, 32'h2);
    wait_done(REPORT_CLKS + 100, fs, da);
    chk("second_done_cycle", da - c0, LATENCY + REPORT_CLKS);
    extra_low = 0;
    for (int i = 0; i < 100; i++) begin
      step(1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 32'h2);
      if (s_uart !== 1'b1) extra_low++;
    end
    chk("second_no_rereport", extra_low, 0);
    chk("second_led", s_led, 1'b1);

    // Reset in the middle of byte 6.
    step(0, 1, 0, 0);
    step(1, 1, 1, 32'h55);
    repeat (LATENCY + 6 * 10 * int'(CPB) + 13) step(1, 1, 0, 0);
    step(0, 0, 0, 0);
    chk("rst_mid_passthru_lo", s_uart, 1'b0);
    chk("rst_mid_done", s_done, 1'b0);
    step(0, 1, 0, 0);
    chk("rst_mid_passthru_hi", s_uart, 1'b1);
    report_case(32'h0, "after_rst");

`ifdef EXIT_REPORT_VERDICT_EN
    report_case(32'h0, "verdict_pass");
    report_case(32'h80000000, "verdict_fail");
`endif

    // Randomized rounds: random idle traffic, capture, bursty activity, optional abort.
    for (int r = 0; r < 15; r++) begin
      step(0, 1, 0, 0);
      repeat ($urandom_range(0, 30)) step(1, 1'($urandom_range(0, 1)), 0, $urandom);
      val = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
      step(1, 1'($urandom_range(0, 1)), 1, val);
      repeat ($urandom_range(0, 60))
        step(1, ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), $urandom);
      abort_at = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 600)) : -1;
      n = 0;
      while (!m_done && n < 3000) begin
        if (n == abort_at) begin
          step(0, 1'($urandom_range(0, 1)), 0, 0);
          step(1, 1, 1, $urandom);
        end
        step(1, 1, ($urandom_range(0, 7) == 0), $urandom);
        n++;
      end
      repeat (3) step(1, 1'($urandom_range(0, 1)), 0, 0);
      chk("random_done_held", s_done, 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
